ac_table_loader: RTL

- Writer-side counterpart to the table reader path: loads the Aho-Corasick goto and failure tables into GOTO_RAM and FAILURE_RAM before matching starts.
- Accepts a byte stream over a valid/ready handshake, first clears both tables, then decodes 3-byte records into single-cycle RAM write strobes.
- Sits between the host/config interface and the write ports of both RAMs.

---
 rtl/ac_table_loader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ac_table_loader.sv
// ac_table_loader: clears the Aho-Corasick goto and failure tables, then
// decodes a header/state/value byte stream into single-cycle RAM writes.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | after reset, waiting for start
//  CLEAR | sweeping both RAMs with their clear values
//  HDR   | waiting for a record header byte
//  STA   | waiting for the state byte of a record
//  VAL   | waiting for the value byte of a record
//  WR    | the record's write strobe is on the RAM port
//  DONE  | end record seen; load complete
//  ERR   | reserved header type seen; stream rejected
module ac_table_loader #(
    parameter int unsigned         ADDR_W   = 12,
    parameter int unsigned         STATE_W  = 8,
    parameter int unsigned         CHAR_W   = 4,
    parameter logic [STATE_W-1:0]  GOTO_CLR = 8'hFF,
    parameter logic [STATE_W-1:0]  FAIL_CLR = 8'h00
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [7:0]         in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic               we_g_o,
    output logic [ADDR_W-1:0]  waddr_g_o,
    output logic [STATE_W-1:0] wdata_g_o,
    output logic               we_f_o,
    output logic [ADDR_W-1:0]  waddr_f_o,
    output logic [STATE_W-1:0] wdata_f_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [15:0]        rec_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_HDR   = 3'd2,
        S_STA   = 3'd3,
        S_VAL   = 3'd4,
        S_WR    = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_e;

    localparam int unsigned PAD_W = ADDR_W - STATE_W;

    state_e               state_q;
    logic [ADDR_W-1:0]    clr_cnt_q;
    logic [ADDR_W-1:0]    clr_inc;
    logic                 is_fail_q;
    logic [CHAR_W-1:0]    chara_q;
    logic [STATE_W-1:0]   st_q;

    logic                 in_ready_q;
    logic                 we_g_q;
    logic [ADDR_W-1:0]    waddr_g_q;
    logic [STATE_W-1:0]   wdata_g_q;
    logic                 we_f_q;
    logic [ADDR_W-1:0]    waddr_f_q;
    logic [STATE_W-1:0]   wdata_f_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic [15:0]          rec_cnt_q;

    logic                 take;

    assign clr_inc = clr_cnt_q + 1'b1;
    assign take    = in_valid_i & in_ready_q;

    // Sequencer: clear sweep, record decode and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            clr_cnt_q  <= '0;
            is_fail_q  <= 1'b0;
            chara_q    <= '0;
            st_q       <= '0;
            in_ready_q <= 1'b0;
            we_g_q     <= 1'b0;
            waddr_g_q  <= '0;
            wdata_g_q  <= '0;
            we_f_q     <= 1'b0;
            waddr_f_q  <= '0;
            wdata_f_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rec_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        // First clear address goes out in the first CLEAR cycle.
                        state_q   <= S_CLEAR;
                        clr_cnt_q <= '0;
                        we_g_q    <= 1'b1;
                        waddr_g_q <= '0;
                        wdata_g_q <= GOTO_CLR;
                        we_f_q    <= 1'b1;
                        waddr_f_q <= '0;
                        wdata_f_q <= FAIL_CLR;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        rec_cnt_q <= '0;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt_q == '1) begin
                        state_q    <= S_HDR;
                        we_g_q     <= 1'b0;
                        we_f_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_inc;
                        waddr_g_q <= clr_inc;
                        // Failure RAM only spans the state range.
                        we_f_q    <= (clr_inc[ADDR_W-1:STATE_W] == '0);
                        waddr_f_q <= {{PAD_W{1'b0}}, clr_inc[STATE_W-1:0]};
                    end
                end
                S_HDR: begin
                    if (take) begin
                        case (in_data_i[7:6])
                            2'b00, 2'b01: begin
                                is_fail_q <= in_data_i[6];
                                chara_q   <= in_data_i[CHAR_W-1:0];
                                state_q   <= S_STA;
                            end
                            2'b10: begin
                                state_q    <= S_DONE;
                                in_ready_q <= 1'b0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                            end
                            default: begin
                                state_q    <= S_ERR;
                                in_ready_q <= 1'b0;
                                busy_q     <= 1'b0;
                                err_q      <= 1'b1;
                            end
                        endcase
                    end
                end
                S_STA: begin
                    if (take) begin
                        st_q    <= in_data_i;
                        state_q <= S_VAL;
                    end
                end
                S_VAL: begin
                    if (take) begin
                        state_q    <= S_WR;
                        in_ready_q <= 1'b0;
                        if (is_fail_q) begin
                            we_f_q    <= 1'b1;
                            waddr_f_q <= {{PAD_W{1'b0}}, st_q};
                            wdata_f_q <= in_data_i;
                        end else begin
                            we_g_q    <= 1'b1;
                            waddr_g_q <= {st_q, chara_q};
                            wdata_g_q <= in_data_i;
                        end
                    end
                end
                S_WR: begin
                    state_q    <= S_HDR;
                    in_ready_q <= 1'b1;
                    we_g_q     <= 1'b0;
                    we_f_q     <= 1'b0;
                    if (rec_cnt_q != 16'hFFFF) begin
                        rec_cnt_q <= rec_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o = in_ready_q;
    assign we_g_o     = we_g_q;
    assign waddr_g_o  = waddr_g_q;
    assign wdata_g_o  = wdata_g_q;
    assign we_f_o     = we_f_q;
    assign waddr_f_o  = waddr_f_q;
    assign wdata_f_o  = wdata_f_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign rec_cnt_o  = rec_cnt_q;

endmodule
